// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the pipeline and the multiply/divide unit.
//   master (pipeline): start, op, opA, opB, hiWrite, loWrite, writeData -> unit
//   slave  (unit):     busy, done, divZero, hi, lo -> pipeline
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             hiWrite;
    logic             loWrite;
    logic [WIDTH-1:0] writeData;
    logic             busy;
    logic             done;
    logic             divZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, opA, opB, hiWrite, loWrite, writeData,
        input  busy, done, divZero, hi, lo
    );

    modport slave (
        input  start, op, opA, opB, hiWrite, loWrite, writeData,
        output busy, done, divZero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers, fixed 33-edge latency.
//   clk, reset (sync, active-high); bus (muldiv_unit_if.slave):
//   start/op/opA/opB request, hiWrite/loWrite/writeData MTHI/MTLO,
//   busy/done/divZero status, hi/lo results.
//   Macro MULDIV_DIV_EN enables the divider; without it divide requests are ignored.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic reset,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [5:0]       count;
    logic [WIDTH-1:0] acc, lowReg, other, hiR, loR;
    logic [WIDTH-1:0] inMagA, inMagB, nextAcc, nextLow, hiRes, loRes;
    logic [WIDTH:0]   mulSum;
    logic [2*WIDTH-1:0] mulRes;
    logic             aNeg, bNeg, busyR, doneR, idleOrDone, accept;

    assign idleOrDone = (state == IDLE) || (state == DONE);
    assign inMagA = (~bus.op[0] & bus.opA[WIDTH-1]) ? -bus.opA : bus.opA;
    assign inMagB = (~bus.op[0] & bus.opB[WIDTH-1]) ? -bus.opB : bus.opB;

    // Multiply: acc holds the running upper half, lowReg shifts the multiplier out
    // and the product's low bits in, so {acc, lowReg} is the magnitude product at the end.
    assign mulSum = {1'b0, acc} + {1'b0, lowReg[0] ? other : {WIDTH{1'b0}}};
    assign mulRes = (aNeg ^ bNeg) ? -{acc, lowReg} : {acc, lowReg};

`ifdef MULDIV_DIV_EN
    logic             isDiv, divZeroR, fits;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff, quo, rem;

    // Restoring divide: acc is the partial remainder, lowReg shifts the dividend
    // out and the quotient in. A zero divisor always "fits", leaving acc = |opA|.
    assign shifted = {acc, lowReg[WIDTH-1]};
    assign fits    = shifted >= {1'b0, other};
    assign diff    = shifted[WIDTH-1:0] - other;
    assign nextAcc = isDiv ? (fits ? diff : shifted[WIDTH-1:0]) : mulSum[WIDTH:1];
    assign nextLow = isDiv ? {lowReg[WIDTH-2:0], fits} : {mulSum[0], lowReg[WIDTH-1:1]};
    assign quo     = (aNeg ^ bNeg) ? -lowReg : lowReg;
    assign rem     = aNeg ? -acc : acc;
    assign hiRes   = isDiv ? rem : mulRes[2*WIDTH-1:WIDTH];
    assign loRes   = isDiv ? ((other == '0) ? '1 : quo) : mulRes[WIDTH-1:0];
    assign accept  = bus.start & idleOrDone;
    assign bus.divZero = divZeroR;
`else
    assign nextAcc = mulSum[WIDTH:1];
    assign nextLow = {mulSum[0], lowReg[WIDTH-1:1]};
    assign hiRes   = mulRes[2*WIDTH-1:WIDTH];
    assign loRes   = mulRes[WIDTH-1:0];
    assign accept  = bus.start & idleOrDone & ~bus.op[1];
    assign bus.divZero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            busyR <= 1'b0;
            doneR <= 1'b0;
            hiR   <= '0;
            loR   <= '0;
`ifdef MULDIV_DIV_EN
            divZeroR <= 1'b0;
`endif
        end else begin
            doneR <= 1'b0;
`ifdef MULDIV_DIV_EN
            divZeroR <= 1'b0;
`endif
            case (state)
                IDLE, DONE: begin
                    if (bus.hiWrite) hiR <= bus.writeData;
                    if (bus.loWrite) loR <= bus.writeData;
                    state <= accept ? CALC : IDLE;
                    if (accept) begin
                        aNeg  <= ~bus.op[0] & bus.opA[WIDTH-1];
                        bNeg  <= ~bus.op[0] & bus.opB[WIDTH-1];
                        acc   <= '0;
                        count <= '0;
                        busyR <= 1'b1;
`ifdef MULDIV_DIV_EN
                        isDiv  <= bus.op[1];
                        other  <= bus.op[1] ? inMagB : inMagA;
                        lowReg <= bus.op[1] ? inMagA : inMagB;
`else
                        other  <= inMagA;
                        lowReg <= inMagB;
`endif
                    end
                end
                CALC: begin
                    acc    <= nextAcc;
                    lowReg <= nextLow;
                    count  <= count + 6'd1;
                    if (count == 6'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    hiR   <= hiRes;
                    loR   <= loRes;
                    busyR <= 1'b0;
                    doneR <= 1'b1;
`ifdef MULDIV_DIV_EN
                    divZeroR <= isDiv && (other == '0);
`endif
                    state <= DONE;
                end
            endcase
        end
    end

    assign bus.busy = busyR;
    assign bus.done = doneR;
    assign bus.hi   = hiR;
    assign bus.lo   = loR;
endmodule
